mc_controller: RTL

- Multicycle control FSM for the RV32I multicycle core variant.
- Sequences the shared datapath: single ALU, single unified memory port, and the IR, OldPC, A, WriteData, ALUOut and Data registers. Each instruction takes several cycles.
- Replaces the single-cycle main decoder plus branch logic. Adds a memory ready/request handshake, a retired-instruction counter and a sticky illegal-opcode trap.

---
 rtl/mc_controller.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mc_controller.sv
// Multicycle RV32I control FSM: sequences the shared datapath, runs the
// memory request/ready handshake, counts retirements and traps illegal ops.
module mc_controller #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 zero,
    input  logic                 lt,
    input  logic                 ltu,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_write,
    output logic                 adr_src,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic [1:0]           result_src,
    output logic [2:0]           imm_src,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD,
        S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
        S_ALUWB, S_BRANCH, S_JAL, S_JALR,
        S_JALRPC, S_LUI, S_AUIPC, S_TRAP
    } state_t;

    state_t state, state_n;
    logic   retire;
    logic   taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_FETCH;
            instret <= '0;
        end else begin
            state <= state_n;
            if (retire)
                instret <= instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        imm_src = 3'b000;
        case (op)
            OP_LOAD, OP_IMM, OP_JALR: imm_src = 3'b000;
            OP_STORE:                 imm_src = 3'b001;
            OP_BRANCH:                imm_src = 3'b010;
            OP_JAL:                   imm_src = 3'b011;
            OP_LUI, OP_AUIPC:         imm_src = 3'b100;
            default:                  imm_src = 3'b000;
        endcase
    end

    // funct3 010/011 are not valid branches; treat as not taken
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = lt;
            3'b101:  taken = ~lt;
            3'b110:  taken = ltu;
            3'b111:  taken = ~ltu;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_n    = state;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_n  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_n = S_MEMADR;
                    OP_OP:             state_n = S_EXECR;
                    OP_IMM:            state_n = S_EXECI;
                    OP_BRANCH:         state_n = S_BRANCH;
                    OP_JAL:            state_n = S_JAL;
                    OP_JALR:           state_n = S_JALR;
                    OP_LUI:            state_n = S_LUI;
                    OP_AUIPC:          state_n = S_AUIPC;
                    default:           state_n = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_n   = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready)
                    state_n = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_n    = S_FETCH;
                retire     = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) begin
                    state_n = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_n   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_n   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_n   = S_FETCH;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_write  = taken;
                state_n   = S_FETCH;
                retire    = 1'b1;
            end
            S_JAL, S_JALRPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_n   = S_ALUWB;
            end
            S_JALR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_n   = S_JALRPC;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                state_n   = S_ALUWB;
            end
            S_AUIPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                state_n   = S_ALUWB;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: state_n = S_FETCH;
        endcase
    end
endmodule
